// File: rtl/rgb2gray_pkg.sv
// Shared constants for the RGB-to-luma pipeline: mode encodings, the
// coefficient table (stored at 8 fractional bits) and the pipeline latency.
package rgb2gray_pkg;

    typedef enum logic [1:0] {
        MODE_BT601 = 2'b00,
        MODE_BT709 = 2'b01,
        MODE_AVG   = 2'b10,
        MODE_GREEN = 2'b11
    } mode_e;

    localparam int LATENCY      = 32'sd3;
    localparam int COEF_BASE_CW = 32'sd8;

    // Rows indexed by mode, columns R/G/B; every row sums to 256.
    localparam logic [8:0] COEF_TABLE [4][3] = '{
        '{9'd77, 9'd150, 9'd29},
        '{9'd54, 9'd183, 9'd19},
        '{9'd85, 9'd86,  9'd85},
        '{9'd0,  9'd256, 9'd0}
    };

    function automatic int unsigned scale_coef(input logic [8:0] c8, input int cw);
        int unsigned v;
        v = 32'(c8);
        if (cw >= COEF_BASE_CW) begin
            return v << (cw - COEF_BASE_CW);
        end else begin
            return (v + (32'd1 << (COEF_BASE_CW - cw - 32'sd1))) >> (COEF_BASE_CW - cw);
        end
    endfunction

endpackage

// File: rtl/rgb2gray_coef.sv
// Combinational mode-to-coefficient lookup, scaled to CW fractional bits.
module rgb2gray_coef
    import rgb2gray_pkg::*;
#(
    parameter int CW = 8
) (
    input  mode_e         i_mode,
    output logic [CW:0]   o_coef_r,
    output logic [CW:0]   o_coef_g,
    output logic [CW:0]   o_coef_b
);

    localparam int          KW    = CW + 32'sd1;
    localparam int unsigned UNITY = 32'd1 << CW;

    int unsigned w_r;
    int unsigned w_b;

    // Green is derived from the other two so each set sums exactly to 2^CW.
    always_comb begin
        w_r = 32'd0;
        w_b = 32'd0;
        case (i_mode)
            MODE_BT601: begin
                w_r = scale_coef(COEF_TABLE[0][0], CW);
                w_b = scale_coef(COEF_TABLE[0][2], CW);
            end
            MODE_BT709: begin
                w_r = scale_coef(COEF_TABLE[1][0], CW);
                w_b = scale_coef(COEF_TABLE[1][2], CW);
            end
            MODE_AVG: begin
                w_r = scale_coef(COEF_TABLE[2][0], CW);
                w_b = scale_coef(COEF_TABLE[2][2], CW);
            end
            MODE_GREEN: begin
                w_r = scale_coef(COEF_TABLE[3][0], CW);
                w_b = scale_coef(COEF_TABLE[3][2], CW);
            end
            default: begin
                w_r = 32'd0;
                w_b = 32'd0;
            end
        endcase
        o_coef_r = KW'(w_r);
        o_coef_b = KW'(w_b);
        o_coef_g = KW'(UNITY - w_r - w_b);
    end

endmodule

// File: rtl/rgb2gray_pipe.sv
// Three-stage RGB-to-luma converter with per-frame mode selection latched at
// start of frame; mode, SOF and valid travel alongside each pixel.
module rgb2gray_pipe
    import rgb2gray_pkg::*;
#(
    parameter int DW = 10,
    parameter int CW = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iDVAL,
    input  logic          iSOF,
    input  logic [1:0]    iMODE,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic          oSOF,
    output logic [1:0]    oMODE
);

    localparam int PW = DW + CW + 32'sd1;
    localparam int SW = DW + CW + 32'sd3;

    logic [1:0]    r_active_mode;
    logic          w_sof;
    logic [1:0]    w_mode;
    logic [CW:0]   w_coef_r;
    logic [CW:0]   w_coef_g;
    logic [CW:0]   w_coef_b;
    logic [PW-1:0] r_prod_r;
    logic [PW-1:0] r_prod_g;
    logic [PW-1:0] r_prod_b;
    logic [SW-1:0] r_sum;
    logic [SW-1:0] w_round;
    logic [DW-1:0] w_luma;
    logic          r_v1;
    logic          r_v2;
    logic          r_sof1;
    logic          r_sof2;
    logic [1:0]    r_mode1;
    logic [1:0]    r_mode2;

    // A qualified SOF pixel already uses the mode it brings with it.
    assign w_sof  = iDVAL & iSOF;
    assign w_mode = w_sof ? iMODE : r_active_mode;

    rgb2gray_coef #(.CW(CW)) u_coef (
        .i_mode   (mode_e'(w_mode)),
        .o_coef_r (w_coef_r),
        .o_coef_g (w_coef_g),
        .o_coef_b (w_coef_b)
    );

    // Round half up, then clamp to the output range.
    always_comb begin
        w_round = (r_sum + (SW'(1'b1) << (CW - 32'sd1))) >> CW;
        if (w_round > SW'({DW{1'b1}})) begin
            w_luma = {DW{1'b1}};
        end else begin
            w_luma = w_round[DW-1:0];
        end
    end

    // Sideband pipeline: valid always shifts, mode/SOF follow their pixel.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_active_mode <= 2'b00;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            oDVAL         <= 1'b0;
            r_sof1        <= 1'b0;
            r_sof2        <= 1'b0;
            oSOF          <= 1'b0;
            r_mode1       <= 2'b00;
            r_mode2       <= 2'b00;
            oMODE         <= 2'b00;
        end else begin
            if (w_sof) r_active_mode <= iMODE;
            r_v1   <= iDVAL;
            r_v2   <= r_v1;
            oDVAL  <= r_v2;
            r_sof1 <= w_sof;
            r_sof2 <= r_sof1;
            oSOF   <= r_sof2;
            if (iDVAL) r_mode1 <= w_mode;
            if (r_v1)  r_mode2 <= r_mode1;
            if (r_v2)  oMODE   <= r_mode2;
        end
    end

    // Datapath stages: products, sum, rounded result; each enabled by its valid.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
            r_sum    <= '0;
            oDATA    <= '0;
        end else begin
            if (iDVAL) begin
                r_prod_r <= PW'(iRed)   * PW'(w_coef_r);
                r_prod_g <= PW'(iGreen) * PW'(w_coef_g);
                r_prod_b <= PW'(iBlue)  * PW'(w_coef_b);
            end
            if (r_v1) r_sum <= SW'(r_prod_r) + SW'(r_prod_g) + SW'(r_prod_b);
            if (r_v2) oDATA <= w_luma;
        end
    end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Self-checking bench for rgb2gray_pipe: directed scenarios plus random
// traffic, all compared against a cycle-level reference model of pixel flow.
module tb_rgb2gray_pipe;

    localparam int DW = 10;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iDVAL;
    logic          iSOF;
    logic [1:0]    iMODE;
    logic [DW-1:0] iRed;
    logic [DW-1:0] iGreen;
    logic [DW-1:0] iBlue;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic          oSOF;
    logic [1:0]    oMODE;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic          dval;
        logic          sof;
        logic [1:0]    mode;
        logic [DW-1:0] data;
    } out_t;

    out_t       pipe_q[$];
    out_t       held;
    logic [1:0] frame_mode;

    always #5 iCLK = ~iCLK;

    rgb2gray_pipe #(.DW(DW), .CW(8)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDVAL  (iDVAL),
        .iSOF   (iSOF),
        .iMODE  (iMODE),
        .iRed   (iRed),
        .iGreen (iGreen),
        .iBlue  (iBlue),
        .oDATA  (oDATA),
        .oDVAL  (oDVAL),
        .oSOF   (oSOF),
        .oMODE  (oMODE)
    );

    function automatic int ref_luma(input logic [1:0] m, input int r, input int g, input int b);
        int cr, cg, cb, y;
        case (m)
            2'b00:   begin cr = 77; cg = 150; cb = 29; end
            2'b01:   begin cr = 54; cg = 183; cb = 19; end
            2'b10:   begin cr = 85; cg = 86;  cb = 85; end
            default: begin cr = 0;  cg = 256; cb = 0;  end
        endcase
        y = (r * cr + g * cg + b * cb + 128) / 256;
        if (y > 1023) y = 1023;
        return y;
    endfunction

    function automatic out_t observed();
        return {oDVAL, oSOF, oMODE, oDATA};
    endfunction

    // Reset leaves two empty stages ahead of the output register.
    task automatic model_reset();
        pipe_q.delete();
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        held       = '0;
        frame_mode = 2'b00;
    endtask

    // Drive one input cycle at the falling edge; return what the outputs must show after the next rising edge.
    task automatic cycle(input logic dv, input logic sof, input logic [1:0] m,
                         input int r, input int g, input int b, output out_t exp);
        out_t e;
        out_t o;
        iDVAL  = dv;
        iSOF   = sof;
        iMODE  = m;
        iRed   = r[DW-1:0];
        iGreen = g[DW-1:0];
        iBlue  = b[DW-1:0];
        e = '0;
        if (dv) begin
            if (sof) frame_mode = m;
            e.dval = 1'b1;
            e.sof  = sof;
            e.mode = frame_mode;
            e.data = 10'(ref_luma(frame_mode, r, g, b));
        end
        pipe_q.push_back(e);
        @(posedge iCLK);
        @(negedge iCLK);
        o = pipe_q.pop_front();
        if (o.dval) begin
            held = o;
        end else begin
            held.dval = 1'b0;
            held.sof  = 1'b0;
        end
        exp = held;
    endtask

    task automatic test_reset();
        out_t e;
        iRST = 1'b0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 2'b11;
        iRed = '0; iGreen = '0; iBlue = '0;
        model_reset();
        repeat (2) @(negedge iCLK);
        n_cmp++;
        if (observed() !== out_t'('0)) begin
            n_err++; $display("FAIL reset_state got %h exp 0", observed());
        end
        iRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 2'b00, 0, 0, 0, e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL post_reset_idle i=%0d got %h exp %h", i, observed(), e);
            end
        end
    endtask

    task automatic test_bt601_white();
        out_t e;
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, i == 0, 2'b00, 1023, 1023, 1023, e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL white_model i=%0d got %h exp %h", i, observed(), e);
            end
            if (i == 2) begin
                n_cmp++;
                if (oDATA !== 10'd1023 || oDVAL !== 1'b1 || oSOF !== 1'b1) begin
                    n_err++; $display("FAIL white_lat3 got data=%0d dval=%b sof=%b exp 1023/1/1", oDATA, oDVAL, oSOF);
                end
            end
        end
    endtask

    task automatic test_bt601_primaries();
        out_t e;
        for (int i = 0; i < 5; i++) begin
            cycle(i < 2, i == 0, 2'b00, (i == 0) ? 1023 : 0, (i == 1) ? 1023 : 0, 0, e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL primaries_model i=%0d got %h exp %h", i, observed(), e);
            end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (oDATA !== ((i == 2) ? 10'd308 : 10'd599)) begin
                    n_err++; $display("FAIL primaries_value i=%0d got %0d exp %0d", i, oDATA, (i == 2) ? 308 : 599);
                end
            end
        end
    endtask

    task automatic test_mode_hold();
        out_t e;
        for (int i = 0; i < 8; i++) begin
            cycle(i < 5, i == 0 || i == 4, (i == 0) ? 2'b01 : 2'b00, 1023, 0, 0, e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL mode_hold_model i=%0d got %h exp %h", i, observed(), e);
            end
            if (i >= 2 && i <= 5) begin
                n_cmp++;
                if (oDATA !== 10'd216 || oMODE !== 2'b01 || oDVAL !== 1'b1) begin
                    n_err++; $display("FAIL mode_hold_709 i=%0d got data=%0d mode=%b exp 216/01", i, oDATA, oMODE);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (oDATA !== 10'd308 || oMODE !== 2'b00 || oSOF !== 1'b1) begin
                    n_err++; $display("FAIL mode_hold_next_sof got data=%0d mode=%b sof=%b exp 308/00/1", oDATA, oMODE, oSOF);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        out_t       e;
        logic [3:0] pat = 4'b1101;
        logic [DW-1:0] first_data = '0;
        for (int i = 0; i < 7; i++) begin
            cycle((i < 4) ? pat[i] : 1'b0, 1'b0, 2'b10, $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023), e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL bubbles_model i=%0d got %h exp %h", i, observed(), e);
            end
            if (i == 2) first_data = e.data;
            if (i >= 2 && i <= 5) begin
                n_cmp++;
                if (oDVAL !== pat[i-2]) begin
                    n_err++; $display("FAIL bubbles_dval i=%0d got %b exp %b", i, oDVAL, pat[i-2]);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (oDATA !== first_data) begin
                    n_err++; $display("FAIL bubbles_hold got %0d exp %0d", oDATA, first_data);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_t e;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, i == 0, 2'b10, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL midreset_fill i=%0d got %h exp %h", i, observed(), e);
            end
        end
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        iRST  = 1'b0;
        #1;
        n_cmp++;
        if (observed() !== out_t'('0)) begin
            n_err++; $display("FAIL midreset_async got %h exp 0", observed());
        end
        @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(i == 4, 1'b0, 2'b11, 1023, 0, 0, e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL midreset_after i=%0d got %h exp %h", i, observed(), e);
            end
            if (i < 6) begin
                n_cmp++;
                if (oDVAL !== 1'b0) begin
                    n_err++; $display("FAIL midreset_ghost i=%0d got dval=%b exp 0", i, oDVAL);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (oDATA !== 10'd308 || oMODE !== 2'b00 || oDVAL !== 1'b1) begin
                    n_err++; $display("FAIL midreset_mode got data=%0d mode=%b exp 308/00", oDATA, oMODE);
                end
            end
        end
    endtask

    task automatic test_passthrough_avg();
        out_t e;
        int   gs[8];
        int   xs[4] = '{0, 1, 512, 1023};
        for (int i = 0; i < 10; i++) begin
            if (i < 8) gs[i] = $urandom_range(0, 1023);
            cycle(i < 8, i == 0, 2'b11, $urandom_range(0, 1023), (i < 8) ? gs[i] : 0,
                  $urandom_range(0, 1023), e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL green_model i=%0d got %h exp %h", i, observed(), e);
            end
            if (i >= 2) begin
                n_cmp++;
                if (oDATA !== 10'(gs[i-2])) begin
                    n_err++; $display("FAIL green_pass i=%0d got %0d exp %0d", i, oDATA, gs[i-2]);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(i < 4, i == 0, 2'b10, (i < 4) ? xs[i] : 0, (i < 4) ? xs[i] : 0, (i < 4) ? xs[i] : 0, e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL avg_model i=%0d got %h exp %h", i, observed(), e);
            end
            if (i >= 2) begin
                n_cmp++;
                if (oDATA !== 10'(xs[i-2]) || oMODE !== 2'b10) begin
                    n_err++; $display("FAIL avg_equal i=%0d got %0d mode=%b exp %0d mode=10", i, oDATA, oMODE, xs[i-2]);
                end
            end
        end
    endtask

    task automatic test_random();
        out_t e;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023),
                  ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023),
                  ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 1023), e);
            n_cmp++;
            if (observed() !== e) begin
                n_err++; $display("FAIL random i=%0d got %h exp %h", i, observed(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bt601_white();
        test_bt601_primaries();
        test_mode_hold();
        test_bubbles();
        test_reset_midstream();
        test_passthrough_avg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
